// File: rtl/usb_status_bank_if.sv
// usb_status_bank_if
//   Groups every datapath-side and register-decoder-side signal of the
//   usb_status_bank.
//   - The master modport is the environment. It drives the per-channel
//     levels, the clear/mask inputs and the EHTS load/ack, and it observes
//     the registered outputs.
//   - The slave modport is the status bank itself.
//   Channel c occupies:
//   - status bits [3c+2:3c]
//   - error bits  [2c+1:2c]
//   - slices [c*W +: W] of the packed occupancy and counter buses.
interface usb_status_bank_if #(
  parameter int NUM_CH = 2,
  parameter int OCC_W  = 7,
  parameter int EHTS_W = 8,
  parameter int CNT_W  = 4
);
  logic [NUM_CH-1:0]        rx_data_ready;
  logic [NUM_CH-1:0]        rx_transfer_active;
  logic [NUM_CH-1:0]        tx_transfer_active;
  logic [NUM_CH-1:0]        rx_error;
  logic [NUM_CH-1:0]        tx_error;
  logic [NUM_CH*OCC_W-1:0]  buffer_occupancy;
  logic [EHTS_W-1:0]        next_ehts_data;
  logic                     ehts_load;
  logic                     ehts_ack;
  logic [2*NUM_CH-1:0]      err_clr;
  logic [NUM_CH-1:0]        cnt_clr;
  logic [NUM_CH-1:0]        hwm_clr;
  logic [2*NUM_CH-1:0]      irq_mask;

  logic [3*NUM_CH-1:0]      status_data;
  logic [2*NUM_CH-1:0]      error_data;
  logic [NUM_CH*CNT_W-1:0]  err_count;
  logic [NUM_CH*OCC_W-1:0]  bo_data;
  logic [NUM_CH*OCC_W-1:0]  bo_hwm;
  logic [EHTS_W-1:0]        ehts_data;
  logic                     ehts_valid;
  logic                     irq;

  modport master (
    output rx_data_ready, rx_transfer_active, tx_transfer_active,
           rx_error, tx_error, buffer_occupancy, next_ehts_data,
           ehts_load, ehts_ack, err_clr, cnt_clr, hwm_clr, irq_mask,
    input  status_data, error_data, err_count, bo_data, bo_hwm,
           ehts_data, ehts_valid, irq
  );

  modport slave (
    input  rx_data_ready, rx_transfer_active, tx_transfer_active,
           rx_error, tx_error, buffer_occupancy, next_ehts_data,
           ehts_load, ehts_ack, err_clr, cnt_clr, hwm_clr, irq_mask,
    output status_data, error_data, err_count, bo_data, bo_hwm,
           ehts_data, ehts_valid, irq
  );
endinterface

// File: rtl/usb_status_bank.sv
// usb_status_bank
//   Multi-channel status/error register bank between the USB RX/TX
//   datapaths and the AHB register decoder. Every output is registered
//   (one cycle latency, no combinational input-to-output path).
//   Ports:
//   - clk : rising-edge system clock
//   - rst : synchronous active-high reset; clears all state, including
//           the error edge history
//   - bus : usb_status_bank_if.slave
//     - inputs : per-channel levels, occupancy, EHTS load/ack,
//                W1C/clear masks, irq mask
//     - outputs: status, sticky errors, saturating error counters,
//                occupancy and its high-water mark, EHTS data/valid, irq
module usb_status_bank #(
  parameter int NUM_CH = 2,
  parameter int OCC_W  = 7,
  parameter int EHTS_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  usb_status_bank_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3*NUM_CH-1:0]     status_q, status_d;
  logic [2*NUM_CH-1:0]     error_q, error_d;
  logic [2*NUM_CH-1:0]     err_in;
  logic [NUM_CH-1:0]       rx_err_hist_q, tx_err_hist_q;
  logic [NUM_CH-1:0]       rx_edge, tx_edge;
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH*OCC_W-1:0] bo_q, bo_d;
  logic [NUM_CH*OCC_W-1:0] hwm_q, hwm_d;
  logic [EHTS_W-1:0]       ehts_data_q, ehts_data_d;
  logic                    ehts_valid_q, ehts_valid_d;
  logic                    irq_q, irq_d;

  // The increment is at most 2, so two guard bits hold any overflow
  // before it is clamped back to the counter width.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0] inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, base} + {{CNT_W{1'b0}}, inc};
    if (sum > {2'b00, CNT_MAX}) begin
      return CNT_MAX;
    end
    return sum[CNT_W-1:0];
  endfunction

  // Error events are rising edges against last cycle's registered level,
  // so an error held high counts only once.
  assign rx_edge = bus.rx_error & ~rx_err_hist_q;
  assign tx_edge = bus.tx_error & ~tx_err_hist_q;

  always_comb begin
    status_d     = '0;
    err_in       = '0;
    cnt_d        = cnt_q;
    bo_d         = bus.buffer_occupancy;
    hwm_d        = hwm_q;
    ehts_data_d  = ehts_data_q;
    ehts_valid_d = ehts_valid_q;

    for (int c = 0; c < NUM_CH; c++) begin
      status_d[3*c +: 3] = {bus.tx_transfer_active[c],
                            bus.rx_transfer_active[c],
                            bus.rx_data_ready[c]};
      err_in[2*c]        = bus.rx_error[c];
      err_in[2*c+1]      = bus.tx_error[c];

      // A clear in the same cycle as an edge leaves the edge count.
      cnt_d[c*CNT_W +: CNT_W] = sat_add(
          bus.cnt_clr[c] ? '0 : cnt_q[c*CNT_W +: CNT_W],
          {1'b0, rx_edge[c]} + {1'b0, tx_edge[c]});

      // A high-water clear reloads the live occupancy rather than zero.
      if (bus.hwm_clr[c] ||
          (bus.buffer_occupancy[c*OCC_W +: OCC_W] > hwm_q[c*OCC_W +: OCC_W])) begin
        hwm_d[c*OCC_W +: OCC_W] = bus.buffer_occupancy[c*OCC_W +: OCC_W];
      end
    end

    // Sticky: set beats the W1C clear in the same cycle.
    error_d = err_in | (error_q & ~bus.err_clr);

    // Load wins over ack, and it overwrites unread data.
    if (bus.ehts_load) begin
      ehts_data_d  = bus.next_ehts_data;
      ehts_valid_d = 1'b1;
    end else if (bus.ehts_ack) begin
      ehts_valid_d = 1'b0;
    end

    // Computed from next-state errors so irq moves with error_data.
    irq_d = |(error_d & bus.irq_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q      <= '0;
      error_q       <= '0;
      rx_err_hist_q <= '0;
      tx_err_hist_q <= '0;
      cnt_q         <= '0;
      bo_q          <= '0;
      hwm_q         <= '0;
      ehts_data_q   <= '0;
      ehts_valid_q  <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      status_q      <= status_d;
      error_q       <= error_d;
      rx_err_hist_q <= bus.rx_error;
      tx_err_hist_q <= bus.tx_error;
      cnt_q         <= cnt_d;
      bo_q          <= bo_d;
      hwm_q         <= hwm_d;
      ehts_data_q   <= ehts_data_d;
      ehts_valid_q  <= ehts_valid_d;
      irq_q         <= irq_d;
    end
  end

  assign bus.status_data = status_q;
  assign bus.error_data  = error_q;
  assign bus.err_count   = cnt_q;
  assign bus.bo_data     = bo_q;
  assign bus.bo_hwm      = hwm_q;
  assign bus.ehts_data   = ehts_data_q;
  assign bus.ehts_valid  = ehts_valid_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_usb_status_bank.sv
// tb_usb_status_bank
//   Directed and random stimulus for usb_status_bank.
//   - A per-channel behavioural model (plain integers and bits) tracks the
//     expected register contents. A negedge process compares every output
//     against it.
//   - The directed part also pins known values with literal expectations.
module tb_usb_status_bank;

  localparam int NUM_CH  = 2;
  localparam int OCC_W   = 7;
  localparam int EHTS_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  usb_status_bank_if #(.NUM_CH(NUM_CH), .OCC_W(OCC_W), .EHTS_W(EHTS_W), .CNT_W(CNT_W)) bus();

  usb_status_bank #(.NUM_CH(NUM_CH), .OCC_W(OCC_W), .EHTS_W(EHTS_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;
  bit compareOn  = 1'b0;

  // Behavioural model state, one entry per channel.
  bit mRdy[NUM_CH], mRxAct[NUM_CH], mTxAct[NUM_CH];
  bit mRxErr[NUM_CH], mTxErr[NUM_CH];
  bit prevRx[NUM_CH], prevTx[NUM_CH];
  int mCnt[NUM_CH], mBo[NUM_CH], mHwm[NUM_CH];
  int mEhts;
  bit mValid, mIrq;

  // The model updates on each rising edge from the inputs sampled there.
  always @(posedge clk) begin : model
    int edges, base, occ;
    bit anyIrq;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mRdy[c] = 0; mRxAct[c] = 0; mTxAct[c] = 0;
        mRxErr[c] = 0; mTxErr[c] = 0; prevRx[c] = 0; prevTx[c] = 0;
        mCnt[c] = 0; mBo[c] = 0; mHwm[c] = 0;
      end
      mEhts = 0; mValid = 0; mIrq = 0;
    end else begin
      anyIrq = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        mRdy[c]   = bus.rx_data_ready[c];
        mRxAct[c] = bus.rx_transfer_active[c];
        mTxAct[c] = bus.tx_transfer_active[c];

        if (bus.rx_error[c]) mRxErr[c] = 1;
        else if (bus.err_clr[2*c]) mRxErr[c] = 0;
        if (bus.tx_error[c]) mTxErr[c] = 1;
        else if (bus.err_clr[2*c+1]) mTxErr[c] = 0;
        if (mRxErr[c] && bus.irq_mask[2*c]) anyIrq = 1;
        if (mTxErr[c] && bus.irq_mask[2*c+1]) anyIrq = 1;

        edges = 0;
        if (bus.rx_error[c] && !prevRx[c]) edges++;
        if (bus.tx_error[c] && !prevTx[c]) edges++;
        prevRx[c] = bus.rx_error[c];
        prevTx[c] = bus.tx_error[c];
        base = bus.cnt_clr[c] ? 0 : mCnt[c];
        mCnt[c] = (base + edges > CNT_MAX) ? CNT_MAX : base + edges;

        occ = int'(bus.buffer_occupancy[c*OCC_W +: OCC_W]);
        mBo[c] = occ;
        if (bus.hwm_clr[c]) mHwm[c] = occ;
        else if (occ > mHwm[c]) mHwm[c] = occ;
      end
      mIrq = anyIrq;
      if (bus.ehts_load) begin
        mEhts  = int'(bus.next_ehts_data);
        mValid = 1;
      end else if (bus.ehts_ack) begin
        mValid = 0;
      end
    end
  end

  function automatic logic [63:0] expStatus();
    logic [63:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[3*c] = mRdy[c]; v[3*c+1] = mRxAct[c]; v[3*c+2] = mTxAct[c];
    end
    return v;
  endfunction

  function automatic logic [63:0] expErr();
    logic [63:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[2*c] = mRxErr[c]; v[2*c+1] = mTxErr[c];
    end
    return v;
  endfunction

  function automatic logic [63:0] packField(input int vals[NUM_CH], input int w);
    logic [63:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v = v | (64'(vals[c]) << (c*w));
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("status_data", 64'(bus.status_data), expStatus());
      checkOutput("error_data",  64'(bus.error_data),  expErr());
      checkOutput("err_count",   64'(bus.err_count),   packField(mCnt, CNT_W));
      checkOutput("bo_data",     64'(bus.bo_data),     packField(mBo, OCC_W));
      checkOutput("bo_hwm",      64'(bus.bo_hwm),      packField(mHwm, OCC_W));
      checkOutput("ehts_data",   64'(bus.ehts_data),   64'(mEhts));
      checkOutput("ehts_valid",  64'(bus.ehts_valid),  64'(mValid));
      checkOutput("irq",         64'(bus.irq),         64'(mIrq));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit allOnes);
    bus.rx_data_ready      = allOnes ? '1 : '0;
    bus.rx_transfer_active = allOnes ? '1 : '0;
    bus.tx_transfer_active = allOnes ? '1 : '0;
    bus.rx_error           = allOnes ? '1 : '0;
    bus.tx_error           = allOnes ? '1 : '0;
    bus.buffer_occupancy   = allOnes ? '1 : '0;
    bus.next_ehts_data     = allOnes ? '1 : '0;
    bus.ehts_load          = allOnes;
    bus.ehts_ack           = allOnes;
    bus.err_clr            = allOnes ? '1 : '0;
    bus.cnt_clr            = '0;
    bus.hwm_clr            = allOnes ? '1 : '0;
    bus.irq_mask           = allOnes ? '1 : '0;
  endtask

  initial begin
    // Reset dominates with every input driven high.
    rst = 1'b1;
    applyStimulus(1'b1);
    bus.cnt_clr = '1;
    step();
    step();
    checkOutput("rst status",   64'(bus.status_data), 64'h0);
    checkOutput("rst error",    64'(bus.error_data),  64'h0);
    checkOutput("rst count",    64'(bus.err_count),   64'h0);
    checkOutput("rst bo",       64'(bus.bo_data),     64'h0);
    checkOutput("rst hwm",      64'(bus.bo_hwm),      64'h0);
    checkOutput("rst ehts",     64'(bus.ehts_data),   64'h0);
    checkOutput("rst valid",    64'(bus.ehts_valid),  64'h0);
    checkOutput("rst irq",      64'(bus.irq),         64'h0);
    rst = 1'b0;
    applyStimulus(1'b0);
    compareOn = 1'b1;
    step();

    // Sticky errors.
    bus.rx_error = 2'b01; step();
    bus.rx_error = 2'b00; bus.tx_error = 2'b10; step();
    bus.tx_error = 2'b00; step();
    checkOutput("sticky set", 64'(bus.error_data), 64'b1001);
    step();
    checkOutput("sticky hold", 64'(bus.error_data), 64'b1001);
    bus.err_clr = 4'b0001; step();
    checkOutput("w1c rx0", 64'(bus.error_data), 64'b1000);
    bus.err_clr = 4'b1000; bus.tx_error = 2'b10; step();
    checkOutput("set beats clr", 64'(bus.error_data), 64'b1000);
    bus.tx_error = 2'b00; bus.err_clr = 4'b1111; step();
    checkOutput("clear all", 64'(bus.error_data), 64'b0000);
    bus.err_clr = '0;

    // Counters.
    bus.cnt_clr = 2'b11; step();
    checkOutput("cnt clr", 64'(bus.err_count), 64'h00);
    bus.cnt_clr = 2'b00;
    for (int i = 0; i < 20; i++) begin
      bus.rx_error = 2'b01; step();
      bus.rx_error = 2'b00; step();
    end
    checkOutput("cnt saturate", 64'(bus.err_count[3:0]), 64'd15);
    bus.rx_error = 2'b10; bus.tx_error = 2'b10; step();
    checkOutput("cnt double", 64'(bus.err_count[7:4]), 64'd2);
    bus.rx_error = 2'b00; bus.tx_error = 2'b00; step();
    bus.rx_error = 2'b10;
    for (int i = 0; i < 10; i++) step();
    checkOutput("cnt held", 64'(bus.err_count[7:4]), 64'd3);
    bus.rx_error = 2'b00; step();
    bus.cnt_clr = 2'b01; bus.rx_error = 2'b01; step();
    checkOutput("cnt clr+edge", 64'(bus.err_count[3:0]), 64'd1);
    bus.cnt_clr = 2'b00; bus.rx_error = 2'b00; bus.err_clr = '1; step();
    bus.err_clr = '0;

    // High-water mark.
    bus.buffer_occupancy = 14'h12; step();
    bus.buffer_occupancy = 14'h4F; step();
    bus.buffer_occupancy = 14'h01; step();
    checkOutput("bo cur", 64'(bus.bo_data[6:0]), 64'h01);
    checkOutput("hwm peak", 64'(bus.bo_hwm[6:0]), 64'h4F);
    bus.hwm_clr = 2'b01; step();
    checkOutput("hwm clr", 64'(bus.bo_hwm[6:0]), 64'h01);
    bus.hwm_clr = 2'b00;

    // EHTS handshake.
    bus.next_ehts_data = 8'h3A; bus.ehts_load = 1'b1; step();
    checkOutput("ehts load", 64'(bus.ehts_data), 64'h3A);
    checkOutput("ehts valid", 64'(bus.ehts_valid), 64'h1);
    bus.next_ehts_data = 8'h12; bus.ehts_ack = 1'b1; step();
    checkOutput("ehts load+ack", 64'(bus.ehts_data), 64'h12);
    checkOutput("ehts valid keep", 64'(bus.ehts_valid), 64'h1);
    bus.ehts_load = 1'b0; step();
    checkOutput("ehts ack data", 64'(bus.ehts_data), 64'h12);
    checkOutput("ehts ack valid", 64'(bus.ehts_valid), 64'h0);
    bus.ehts_ack = 1'b0;

    // Interrupt masking.
    bus.rx_error = 2'b01; step();
    checkOutput("irq err set", 64'(bus.error_data[0]), 64'h1);
    checkOutput("irq masked", 64'(bus.irq), 64'h0);
    bus.rx_error = 2'b00; bus.irq_mask = 4'b0001; step();
    checkOutput("irq raise", 64'(bus.irq), 64'h1);
    bus.err_clr = 4'b0001; step();
    checkOutput("irq drop", 64'(bus.irq), 64'h0);
    bus.err_clr = '0;

    // Random phase, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.rx_data_ready      = NUM_CH'($urandom);
      bus.rx_transfer_active = NUM_CH'($urandom);
      bus.tx_transfer_active = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0) bus.rx_error[c] = ~bus.rx_error[c];
        if ($urandom_range(0, 3) == 0) bus.tx_error[c] = ~bus.tx_error[c];
        bus.cnt_clr[c] = ($urandom_range(0, 40) == 0);
        bus.hwm_clr[c] = ($urandom_range(0, 30) == 0);
      end
      bus.buffer_occupancy = (NUM_CH*OCC_W)'($urandom);
      bus.next_ehts_data   = EHTS_W'($urandom);
      bus.ehts_load        = ($urandom_range(0, 3) == 0);
      bus.ehts_ack         = ($urandom_range(0, 2) == 0);
      bus.err_clr          = ($urandom_range(0, 3) == 0) ? (2*NUM_CH)'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) bus.irq_mask = (2*NUM_CH)'($urandom);
      step();
    end
    rst = 1'b0;
    step();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/usb_status_bank.md
# usb_status_bank

Parametrised, multi-channel status/error register bank for the USB-AHB module. It sits between the per-endpoint USB RX/TX datapaths and the AHB slave register decoder. It captures per-channel transfer status, sticky error flags, saturating error-event counters, buffer-occupancy high-water marks and EHTS data, and drives a single maskable interrupt. It generalises the single-channel status/error register block to NUM_CH channels and adds flag clearing, event counting, high-water tracking and an EHTS valid/ack handshake.

## Interface
- NUM_CH, 2, number of USB channels (1..8)
- OCC_W, 7, buffer-occupancy width per channel
- EHTS_W, 8, EHTS data width
- CNT_W, 4, error-event counter width per channel
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- rx_data_ready  in  NUM_CH  per-channel RX data ready level
- rx_transfer_active  in  NUM_CH  per-channel RX transfer active level
- tx_transfer_active  in  NUM_CH  per-channel TX transfer active level
- rx_error  in  NUM_CH  per-channel RX error level/pulse
- tx_error  in  NUM_CH  per-channel TX error level/pulse
- buffer_occupancy  in  NUM_CH*OCC_W  channel c occupies bits [c*OCC_W +: OCC_W]
- next_ehts_data  in  EHTS_W  EHTS data candidate
- ehts_load  in  1  capture next_ehts_data
- ehts_ack  in  1  consumer has read ehts_data
- err_clr  in  2*NUM_CH  W1C mask for error_data
- cnt_clr  in  NUM_CH  clear error counter of channel c
- hwm_clr  in  NUM_CH  clear high-water mark of channel c
- irq_mask  in  2*NUM_CH  1 = error bit may raise irq
- status_data  out  3*NUM_CH  channel c bits [3c+2:3c] = {tx_active, rx_active, rx_data_ready}
- error_data  out  2*NUM_CH  channel c bits [2c+1:2c] = {tx_err, rx_err}, sticky
- err_count  out  NUM_CH*CNT_W  saturating error-event count per channel
- bo_data  out  NUM_CH*OCC_W  registered current occupancy
- bo_hwm  out  NUM_CH*OCC_W  occupancy high-water mark
- ehts_data  out  EHTS_W  captured EHTS data
- ehts_valid  out  1  ehts_data is unread
- irq  out  1  interrupt request

## Operation
- All outputs are registered. When rst is high at a rising edge, every output and internal register (including edge-detect history) becomes 0.
- status_data: plain sample of the three level inputs every cycle. Not sticky.
- error_data bit:
  - Set when the corresponding error input is 1.
  - Otherwise cleared when the matching err_clr bit is 1.
  - Otherwise holds.
  - Set beats clear in the same cycle.
- Error events: rising edges of rx_error[c] and tx_error[c], detected against the previous-cycle registered value.
  - err_count[c] += number of rising edges this cycle (0, 1 or 2), saturating at 2^CNT_W-1. It never wraps.
  - cnt_clr[c] forces 0. If an edge arrives in the same cycle as cnt_clr, the result is the edge count, not 0.
  - A held-high error counts once.
- bo_data[c] tracks buffer_occupancy[c].
- bo_hwm[c]:
  - Becomes max(bo_hwm[c], buffer_occupancy[c]) each cycle.
  - hwm_clr[c] loads the current buffer_occupancy[c] instead of 0.
- EHTS handshake:
  - ehts_load: ehts_data is loaded from next_ehts_data and ehts_valid is set to 1. This happens even if ehts_valid is already 1; the old data is overwritten.
  - ehts_ack with no load: ehts_valid clears and ehts_data holds.
  - load and ack in the same cycle: load wins, and ehts_valid stays 1.
- irq is 1 when the result of (error_data & irq_mask), computed on the next-state error_data, is non-zero. It is registered in the same cycle as error_data.

## Timing
- Latency from input to output is 1 cycle for every path: status, error set/clear, counter, occupancy, hwm, EHTS, irq.
- An error pulse at edge N is visible on error_data and irq after edge N and stays until cleared.
- err_clr and cnt_clr take effect at the edge where they are sampled high.
- Reset dominates every other input in the same cycle.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset: drive all inputs nonzero with rst=1 for 2 cycles. Every output must be 0, including irq and ehts_valid.
- Sticky errors, NUM_CH=2:
  - rx_error[0] pulses for 1 cycle, then tx_error[1] pulses. Expect error_data=4'b1001, which holds.
  - err_clr=4'b0001 gives 4'b1000.
  - err_clr=4'b1000 with tx_error[1]=1 in the same cycle leaves 4'b1000.
- Counter:
  - 20 separate rx_error pulses on channel 0 give err_count[0]=15 (saturated).
  - rx_error and tx_error rising together on channel 1 give +2.
  - Holding rx_error high for 10 cycles gives +1 only.
- High-water mark:
  - Occupancy sequence 0x12, 0x4F, 0x01 gives bo_data=0x01 and bo_hwm=0x4F.
  - hwm_clr gives bo_hwm=0x01.
- EHTS:
  - Load 0x3A gives ehts_data=0x3A, ehts_valid=1.
  - Load 0x12 and ack in the same cycle give 0x12, valid=1.
  - Ack alone gives valid=0 and data 0x12.
- irq:
  - With irq_mask=0, an error sets error_data but irq stays 0.
  - Setting the mask bit raises irq 1 cycle later.
  - Clearing the error with err_clr drops irq 1 cycle later.
